// File: rtl/branch_issue_sched.sv
// branch_issue_sched: collapsing-queue reservation station for the branch FU.
// Captures operands from the CDB, issues the oldest ready op, and tracks its ROB tag to the FU result.
module branch_issue_sched #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic [4:0]                 alloc_opcode,
    input  logic [2:0]                 alloc_branch_type,
    input  logic                       alloc_additional_info,
    input  logic [XLEN-1:0]            alloc_pc,
    input  logic [XLEN-1:0]            alloc_offset,
    input  logic [TAG_W-1:0]           alloc_rob_tag,
    input  logic                       alloc_rs1_rdy,
    input  logic                       alloc_rs2_rdy,
    input  logic [XLEN-1:0]            alloc_rs1_val,
    input  logic [XLEN-1:0]            alloc_rs2_val,
    input  logic [TAG_W-1:0]           alloc_rs1_tag,
    input  logic [TAG_W-1:0]           alloc_rs2_tag,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [XLEN-1:0]            cdb_data,
    input  logic                       flush,
    output logic                       fu_valid,
    output logic [4:0]                 fu_opcode,
    output logic [2:0]                 fu_branch_type,
    output logic                       fu_additional_info,
    output logic [XLEN-1:0]            fu_rs1,
    output logic [XLEN-1:0]            fu_rs2,
    output logic [XLEN-1:0]            fu_pc,
    output logic [XLEN-1:0]            fu_offset,
    output logic                       res_valid,
    output logic [TAG_W-1:0]           res_rob_tag,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic [4:0]       opcode;
        logic [2:0]       btype;
        logic             add;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  off;
        logic [TAG_W-1:0] rob;
        logic             r1_rdy;
        logic [XLEN-1:0]  r1_val;
        logic [TAG_W-1:0] r1_tag;
        logic             r2_rdy;
        logic [XLEN-1:0]  r2_val;
        logic [TAG_W-1:0] r2_tag;
    } entry_t;

    entry_t           q [DEPTH];
    entry_t           nq [DEPTH];
    entry_t           in_e;
    logic [DEPTH-1:0] rdy;
    logic [IW-1:0]    sel;
    logic             issue;
    logic             fire;
    logic             jal_like;
    logic             jalr;
    logic [CW-1:0]    wpos;
    logic [TAG_W-1:0] fu_tag;
    logic [TAG_W-1:0] p1_tag;
    logic             p1_valid;

    function automatic entry_t wake(input entry_t e, input logic cv, input logic [TAG_W-1:0] t,
                                    input logic [XLEN-1:0] d);
        entry_t w;
        w = e;
        if (cv && !e.r1_rdy && e.r1_tag == t) begin
            w.r1_rdy = 1'b1;
            w.r1_val = d;
        end
        if (cv && !e.r2_rdy && e.r2_tag == t) begin
            w.r2_rdy = 1'b1;
            w.r2_val = d;
        end
        return w;
    endfunction

    assign alloc_ready = count < CW'(DEPTH);
    assign fire        = alloc_valid && alloc_ready;
    assign issue       = |rdy;
    assign wpos        = count - CW'(issue);
    assign jal_like    = alloc_opcode == 5'b11011 || alloc_opcode == 5'b00101;
    assign jalr        = alloc_opcode == 5'b11001;

    always_comb begin
        rdy = '0;
        sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = CW'(i) < count && q[i].r1_rdy && q[i].r2_rdy;
            sel    = rdy[i] ? IW'(i) : sel;
        end
    end

    // Incoming op sees the same-cycle broadcast so it cannot miss its producer.
    always_comb begin
        in_e = '{opcode: alloc_opcode, btype: alloc_branch_type, add: alloc_additional_info,
                 pc: alloc_pc, off: alloc_offset, rob: alloc_rob_tag,
                 r1_rdy: alloc_rs1_rdy || jal_like, r1_val: alloc_rs1_val, r1_tag: alloc_rs1_tag,
                 r2_rdy: alloc_rs2_rdy || jal_like || jalr, r2_val: alloc_rs2_val, r2_tag: alloc_rs2_tag};
        in_e = wake(in_e, cdb_valid, cdb_tag, cdb_data);
    end

    // Collapse over the issued slot first, then wake, then drop the new op at the tail.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            nq[i] = (issue && IW'(i) >= sel) ? q[(i + 1) % DEPTH] : q[i];
            nq[i] = wake(nq[i], cdb_valid, cdb_tag, cdb_data);
            nq[i] = (fire && wpos == CW'(i)) ? in_e : nq[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            count              <= '0;
            fu_valid           <= 1'b0;
            fu_opcode          <= '0;
            fu_branch_type     <= '0;
            fu_additional_info <= 1'b0;
            fu_rs1             <= '0;
            fu_rs2             <= '0;
            fu_pc              <= '0;
            fu_offset          <= '0;
            fu_tag             <= '0;
            p1_valid           <= 1'b0;
            p1_tag             <= '0;
            res_valid          <= 1'b0;
            res_rob_tag        <= '0;
        end else if (flush) begin
            count     <= '0;
            fu_valid  <= 1'b0;
            p1_valid  <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) q[i] <= nq[i];
            count    <= count + CW'(fire) - CW'(issue);
            fu_valid <= issue;
            if (issue) begin
                fu_opcode          <= q[sel].opcode;
                fu_branch_type     <= q[sel].btype;
                fu_additional_info <= q[sel].add;
                fu_rs1             <= q[sel].r1_val;
                fu_rs2             <= q[sel].r2_val;
                fu_pc              <= q[sel].pc;
                fu_offset          <= q[sel].off;
                fu_tag             <= q[sel].rob;
            end
            p1_valid    <= fu_valid;
            p1_tag      <= fu_tag;
            res_valid   <= p1_valid;
            res_rob_tag <= p1_tag;
        end
    end
endmodule

// File: tb/tb_branch_issue_sched.sv
// tb_branch_issue_sched: directed vectors with hand-computed expectations for branch_issue_sched.
module tb_branch_issue_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alloc_valid = 1'b0;
    logic        alloc_ready;
    logic [4:0]  alloc_opcode = '0;
    logic [2:0]  alloc_branch_type = '0;
    logic        alloc_additional_info = 1'b0;
    logic [31:0] alloc_pc = '0, alloc_offset = '0;
    logic [5:0]  alloc_rob_tag = '0;
    logic        alloc_rs1_rdy = 1'b0, alloc_rs2_rdy = 1'b0;
    logic [31:0] alloc_rs1_val = '0, alloc_rs2_val = '0;
    logic [5:0]  alloc_rs1_tag = '0, alloc_rs2_tag = '0;
    logic        cdb_valid = 1'b0;
    logic [5:0]  cdb_tag = '0;
    logic [31:0] cdb_data = '0;
    logic        flush = 1'b0;
    logic        fu_valid;
    logic [4:0]  fu_opcode;
    logic [2:0]  fu_branch_type;
    logic        fu_additional_info;
    logic [31:0] fu_rs1, fu_rs2, fu_pc, fu_offset;
    logic        res_valid;
    logic [5:0]  res_rob_tag;
    logic [2:0]  count;
    int          total = 0;
    int          bad = 0;

    branch_issue_sched dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_opcode(alloc_opcode), .alloc_branch_type(alloc_branch_type),
        .alloc_additional_info(alloc_additional_info),
        .alloc_pc(alloc_pc), .alloc_offset(alloc_offset), .alloc_rob_tag(alloc_rob_tag),
        .alloc_rs1_rdy(alloc_rs1_rdy), .alloc_rs2_rdy(alloc_rs2_rdy),
        .alloc_rs1_val(alloc_rs1_val), .alloc_rs2_val(alloc_rs2_val),
        .alloc_rs1_tag(alloc_rs1_tag), .alloc_rs2_tag(alloc_rs2_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .flush(flush),
        .fu_valid(fu_valid), .fu_opcode(fu_opcode), .fu_branch_type(fu_branch_type),
        .fu_additional_info(fu_additional_info),
        .fu_rs1(fu_rs1), .fu_rs2(fu_rs2), .fu_pc(fu_pc), .fu_offset(fu_offset),
        .res_valid(res_valid), .res_rob_tag(res_rob_tag), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 1'b0;
        cdb_valid   = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic put(input logic [4:0] op, input logic [2:0] bt, input logic ai,
                       input logic [31:0] pc, input logic [31:0] off, input logic [5:0] rob,
                       input logic r1r, input logic [31:0] r1v, input logic [5:0] r1t,
                       input logic r2r, input logic [31:0] r2v, input logic [5:0] r2t);
        alloc_valid = 1'b1;
        alloc_opcode = op; alloc_branch_type = bt; alloc_additional_info = ai;
        alloc_pc = pc; alloc_offset = off; alloc_rob_tag = rob;
        alloc_rs1_rdy = r1r; alloc_rs1_val = r1v; alloc_rs1_tag = r1t;
        alloc_rs2_rdy = r2r; alloc_rs2_val = r2v; alloc_rs2_tag = r2t;
    endtask

    task automatic bcast(input logic [5:0] t, input logic [31:0] d);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_data  = d;
    endtask

    initial begin
        step();
        step();
        check("rst_count", 32'(count), 32'd0);
        check("rst_fu_valid", 32'(fu_valid), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_fu_rs1", fu_rs1, 32'd0);
        check("rst_res_tag", 32'(res_rob_tag), 32'd0);
        rst = 1'b1;
        step();
        check("rst_alloc_ready", 32'(alloc_ready), 32'd1);

        // Ready BEQ: fu_valid two edges after alloc, result two edges later.
        put(5'b11000, 3'd1, 1'b1, 32'h1000, 32'h8, 6'd3, 1'b1, 32'd5, 6'd0, 1'b1, 32'd5, 6'd0);
        step();
        idle();
        check("t1_count_alloc", 32'(count), 32'd1);
        check("t1_no_same_cycle_issue", 32'(fu_valid), 32'd0);
        step();
        check("t1_fu_valid", 32'(fu_valid), 32'd1);
        check("t1_fu_rs1", fu_rs1, 32'd5);
        check("t1_fu_rs2", fu_rs2, 32'd5);
        check("t1_fu_btype", 32'(fu_branch_type), 32'd1);
        check("t1_fu_ai", 32'(fu_additional_info), 32'd1);
        check("t1_fu_pc", fu_pc, 32'h1000);
        check("t1_count_issue", 32'(count), 32'd0);
        step();
        check("t1_fu_valid_drop", 32'(fu_valid), 32'd0);
        check("t1_res_early", 32'(res_valid), 32'd0);
        step();
        check("t1_res_valid", 32'(res_valid), 32'd1);
        check("t1_res_tag", 32'(res_rob_tag), 32'd3);
        step();
        check("t1_res_drop", 32'(res_valid), 32'd0);

        // Younger ready op overtakes; older op woken on CDB issues after it.
        put(5'b11000, 3'd0, 1'b0, 32'h2000, 32'h4, 6'd10, 1'b0, 32'd0, 6'd9, 1'b1, 32'd1, 6'd0);
        step();
        put(5'b11000, 3'd0, 1'b0, 32'h2004, 32'h4, 6'd11, 1'b1, 32'd7, 6'd0, 1'b1, 32'd7, 6'd0);
        step();
        idle();
        check("t2_count", 32'(count), 32'd2);
        check("t2_not_ready", 32'(fu_valid), 32'd0);
        bcast(6'd9, 32'h40);
        step();
        idle();
        check("t2_b_first", fu_rs1, 32'd7);
        check("t2_b_valid", 32'(fu_valid), 32'd1);
        check("t2_count_b", 32'(count), 32'd1);
        step();
        check("t2_a_valid", 32'(fu_valid), 32'd1);
        check("t2_a_rs1", fu_rs1, 32'h40);
        check("t2_a_pc", fu_pc, 32'h2000);
        step();
        check("t2_res_b", 32'(res_rob_tag), 32'd11);
        step();
        check("t2_res_a_valid", 32'(res_valid), 32'd1);
        check("t2_res_a", 32'(res_rob_tag), 32'd10);
        step();

        // Fill, reject 5th, wake middle slot, alloc lands at the tail.
        for (int k = 0; k < 4; k++) begin
            put(5'b11000, 3'd0, 1'b0, 32'h3000 + 32'(k), 32'd0, 6'(20 + k),
                1'b0, 32'd0, 6'(30 + k), 1'b1, 32'd0, 6'd0);
            step();
        end
        check("t3_full_count", 32'(count), 32'd4);
        check("t3_full_ready", 32'(alloc_ready), 32'd0);
        put(5'b11000, 3'd0, 1'b0, 32'h3004, 32'd0, 6'd24, 1'b0, 32'd0, 6'd34, 1'b1, 32'd0, 6'd0);
        step();
        idle();
        check("t3_full_ignored", 32'(count), 32'd4);
        bcast(6'd32, 32'h55);
        step();
        idle();
        check("t3_no_wake_issue", 32'(fu_valid), 32'd0);
        step();
        check("t3_slot2_issue", 32'(fu_valid), 32'd1);
        check("t3_slot2_rs1", fu_rs1, 32'h55);
        check("t3_slot2_pc", fu_pc, 32'h3002);
        check("t3_count3", 32'(count), 32'd3);
        put(5'b11000, 3'd0, 1'b0, 32'h3005, 32'd0, 6'd25, 1'b0, 32'd0, 6'd35, 1'b1, 32'd0, 6'd0);
        step();
        idle();
        check("t3_refill", 32'(count), 32'd4);
        bcast(6'd35, 32'h77);
        step();
        idle();
        step();
        check("t3_tail_rs1", fu_rs1, 32'h77);
        check("t3_tail_pc", fu_pc, 32'h3005);
        bcast(6'd33, 32'h33);
        step();
        idle();
        step();
        check("t3_shifted_rs1", fu_rs1, 32'h33);
        check("t3_shifted_pc", fu_pc, 32'h3003);
        check("t3_count2", 32'(count), 32'd2);
        step();

        // Flush kills pending entries and the in-flight result.
        put(5'b11000, 3'd0, 1'b0, 32'h4000, 32'd0, 6'd40, 1'b1, 32'h99, 6'd0, 1'b1, 32'd0, 6'd0);
        step();
        idle();
        check("t5_count3", 32'(count), 32'd3);
        step();
        check("t5_issued", fu_rs1, 32'h99);
        check("t5_issue_valid", 32'(fu_valid), 32'd1);
        flush = 1'b1;
        step();
        idle();
        check("t5_flush_count", 32'(count), 32'd0);
        check("t5_flush_fu", 32'(fu_valid), 32'd0);
        check("t5_flush_res0", 32'(res_valid), 32'd0);
        step();
        check("t5_flush_res1", 32'(res_valid), 32'd0);
        check("t5_flush_ready", 32'(alloc_ready), 32'd1);
        bcast(6'd30, 32'h1);
        step();
        idle();
        step();
        check("t5_no_revive", 32'(fu_valid), 32'd0);
        check("t5_still_empty", 32'(count), 32'd0);

        // Same-cycle CDB bypass into an allocating op.
        put(5'b11000, 3'd0, 1'b0, 32'h5000, 32'd0, 6'd50, 1'b1, 32'd3, 6'd0, 1'b0, 32'd0, 6'd7);
        bcast(6'd7, 32'h11);
        step();
        idle();
        check("t4_count", 32'(count), 32'd1);
        step();
        check("t4_valid", 32'(fu_valid), 32'd1);
        check("t4_rs2", fu_rs2, 32'h11);
        check("t4_rs1", fu_rs1, 32'd3);
        step();

        // JAL/AUIPC ignore operands; JALR ignores rs2.
        put(5'b11011, 3'd0, 1'b0, 32'h300, 32'h10, 6'd60, 1'b0, 32'd0, 6'd61, 1'b0, 32'd0, 6'd62);
        step();
        check("t6_jal_count", 32'(count), 32'd1);
        put(5'b00101, 3'd0, 1'b0, 32'h100, 32'h20, 6'd61, 1'b0, 32'd0, 6'd62, 1'b0, 32'd0, 6'd63);
        step();
        idle();
        check("t6_jal_valid", 32'(fu_valid), 32'd1);
        check("t6_jal_op", 32'(fu_opcode), 32'b11011);
        check("t6_jal_pc", fu_pc, 32'h300);
        check("t6_alloc_while_issue", 32'(count), 32'd1);
        step();
        check("t6_auipc_valid", 32'(fu_valid), 32'd1);
        check("t6_auipc_op", 32'(fu_opcode), 32'b00101);
        check("t6_auipc_pc", fu_pc, 32'h100);
        check("t6_auipc_off", fu_offset, 32'h20);
        check("t6_count0", 32'(count), 32'd0);
        put(5'b11001, 3'd0, 1'b0, 32'h600, 32'h4, 6'd62, 1'b1, 32'habc, 6'd0, 1'b0, 32'd0, 6'd63);
        step();
        idle();
        step();
        check("t6_jalr_valid", 32'(fu_valid), 32'd1);
        check("t6_jalr_op", 32'(fu_opcode), 32'b11001);
        check("t6_jalr_rs1", fu_rs1, 32'habc);
        step();

        // Asynchronous reset mid-flight drops the issued op's result.
        put(5'b11000, 3'd0, 1'b0, 32'h700, 32'd0, 6'd5, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1, 6'd0);
        step();
        put(5'b11000, 3'd0, 1'b0, 32'h704, 32'd0, 6'd6, 1'b0, 32'd0, 6'd1, 1'b1, 32'd1, 6'd0);
        step();
        idle();
        check("t7_pre_valid", 32'(fu_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("t7_async_fu", 32'(fu_valid), 32'd0);
        check("t7_async_count", 32'(count), 32'd0);
        step();
        rst = 1'b1;
        step();
        check("t7_res_killed", 32'(res_valid), 32'd0);
        step();
        check("t7_res_killed2", 32'(res_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
